// File: rtl/pps_pkg.sv
// Shared constants and FSM state type for the phase report path.
// Defaults match the 4-channel, 29-bit phase, 50 MHz build.
package pps_pkg;
  localparam int NCH_DEF    = 4;
  localparam int PH_W_DEF   = 29;
  localparam int TO_CYC_DEF = 50_000_000;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;
endpackage

// File: rtl/ph_report_sched_if.sv
// Phase snapshot input, record handshake and status signals of ph_report_sched.
// master = scheduler side, slave = measurement/formatter side.
interface ph_report_sched_if #(
  parameter int NCH  = 4,
  parameter int PH_W = 29
);
  logic                i_ph_en;
  logic [NCH*PH_W-1:0] i_ph;
  logic [NCH-1:0]      i_ch_mask;
  logic                o_rec_valid;
  logic                i_rec_ready;
  logic [2:0]          o_rec_ch;
  logic [PH_W-1:0]     o_rec_ph;
  logic                o_rec_last;
  logic [7:0]          o_rec_seq;
  logic                o_busy;
  logic                o_overrun;
  logic                o_timeout;
  logic [7:0]          o_drop_cnt;

  modport master (
    input  i_ph_en, i_ph, i_ch_mask, i_rec_ready,
    output o_rec_valid, o_rec_ch, o_rec_ph, o_rec_last, o_rec_seq,
    output o_busy, o_overrun, o_timeout, o_drop_cnt
  );

  modport slave (
    output i_ph_en, i_ph, i_ch_mask, i_rec_ready,
    input  o_rec_valid, o_rec_ch, o_rec_ph, o_rec_last, o_rec_seq,
    input  o_busy, o_overrun, o_timeout, o_drop_cnt
  );
endinterface

// File: rtl/lsb_pick.sv
// Lowest-set-bit encoder: index of the lowest set bit of vec plus an any flag.
// Purely combinational, no backpressure.
module lsb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [2:0]   idx,
  output logic         any
);
  always_comb begin
    idx = 3'd0;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    any = |vec;
  end
endmodule

// File: rtl/ph_report_sched.sv
// Freezes a phase snapshot per strobe and emits one record per enabled channel, lowest first.
// Strobe -> first record 1 cycle; 1 record/cycle with ready high; stalls hold outputs, watchdog aborts the frame.
module ph_report_sched
  import pps_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int PH_W   = PH_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ph_report_sched_if.master  rep
);
  localparam int WD_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [NCH-1:0] CH_ONE = NCH'(1);

  state_t              state;
  logic [NCH*PH_W-1:0] snap_ph;
  logic [NCH-1:0]      pending;
  logic [WD_W-1:0]     wd_cnt;
  logic                rec_valid;
  logic [2:0]          rec_ch;
  logic [PH_W-1:0]     rec_ph;
  logic                rec_last;
  logic [7:0]          rec_seq;
  logic                busy;
  logic                overrun;
  logic                timeout;
  logic [7:0]          drop_cnt;

  logic [NCH-1:0]      pick_in;
  logic [NCH-1:0]      pick_rest;
  logic [NCH*PH_W-1:0] pick_src;
  logic [PH_W-1:0]     pick_ph;
  logic [2:0]          pick_idx;
  logic                pick_any;
  logic                hs;

  // One encoder serves both the first pick (live mask) and the next pick (remaining pending).
  always_comb begin
    pick_in  = rep.i_ch_mask;
    pick_src = rep.i_ph;
    if (state == ST_SEND) begin
      pick_in  = pending & ~(CH_ONE << rec_ch);
      pick_src = snap_ph;
    end
  end

  lsb_pick #(.N(NCH)) u_pick (
    .vec (pick_in),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_rest = pick_in & ~(CH_ONE << pick_idx);
  assign pick_ph   = pick_src[int'(pick_idx)*PH_W +: PH_W];
  assign hs        = rec_valid & rep.i_rec_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      snap_ph   <= '0;
      pending   <= '0;
      wd_cnt    <= '0;
      rec_valid <= 1'b0;
      rec_ch    <= 3'd0;
      rec_ph    <= '0;
      rec_last  <= 1'b0;
      rec_seq   <= 8'd0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (rep.i_ph_en && state == ST_SEND) begin
        overrun <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (rep.i_ph_en && pick_any) begin
            snap_ph   <= rep.i_ph;
            pending   <= rep.i_ch_mask;
            rec_ch    <= pick_idx;
            rec_ph    <= pick_ph;
            rec_last  <= (pick_rest == '0);
            rec_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (hs) begin
            wd_cnt  <= '0;
            pending <= pick_in;
            if (pick_any) begin
              rec_ch   <= pick_idx;
              rec_ph   <= pick_ph;
              rec_last <= (pick_rest == '0);
            end else begin
              rec_valid <= 1'b0;
              rec_last  <= 1'b0;
              busy      <= 1'b0;
              rec_seq   <= rec_seq + 8'd1;
              state     <= ST_IDLE;
            end
          end else if (wd_cnt == WD_W'(TO_CYC - 1)) begin
            // Abort still consumes the frame number so the host sees the gap.
            timeout   <= 1'b1;
            wd_cnt    <= '0;
            pending   <= '0;
            rec_valid <= 1'b0;
            rec_last  <= 1'b0;
            busy      <= 1'b0;
            rec_seq   <= rec_seq + 8'd1;
            state     <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rep.o_rec_valid = rec_valid;
  assign rep.o_rec_ch    = rec_ch;
  assign rep.o_rec_ph    = rec_ph;
  assign rep.o_rec_last  = rec_last;
  assign rep.o_rec_seq   = rec_seq;
  assign rep.o_busy      = busy;
  assign rep.o_overrun   = overrun;
  assign rep.o_timeout   = timeout;
  assign rep.o_drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_ph_report_sched.sv
// Directed + randomized bench for ph_report_sched against a per-frame expected-record queue.
module tb_ph_report_sched;
  localparam int NCH    = 4;
  localparam int PH_W   = 29;
  localparam int TO_CYC = 16;

  typedef struct {
    int              ch;
    logic [PH_W-1:0] ph;
    logic            last;
  } rec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   exp_seq;
  int   exp_drops;

  ph_report_sched_if #(.NCH(NCH), .PH_W(PH_W)) bus ();

  ph_report_sched #(.NCH(NCH), .PH_W(PH_W), .TO_CYC(TO_CYC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rep   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [NCH*PH_W-1:0] rand_ph();
    logic [NCH*PH_W-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*PH_W +: PH_W] = PH_W'($urandom);
    return v;
  endfunction

  function automatic logic [NCH-1:0] rand_mask_nz();
    return NCH'($urandom_range(1, (1 << NCH) - 1));
  endfunction

  // Called at a negedge; drives the strobe immediately and returns at the
  // negedge after the frame ended (or immediately after a zero-mask strobe).
  // rdy_mode: 0 ready high, 1 ready every third cycle, 2 random.
  // strb_mode bit0: strobe on the first record cycle, bit1: strobe on the last handshake.
  task automatic run_frame(input logic [NCH-1:0] mask, input logic [NCH*PH_W-1:0] ph,
                           input int rdy_mode, input int strb_mode);
    rec_t exp_q[$];
    int   hi;
    int   cyc;
    int   stall;
    logic rdy;
    logic strobed;

    hi = -1;
    for (int i = 0; i < NCH; i++) if (mask[i]) hi = i;
    for (int i = 0; i < NCH; i++)
      if (mask[i]) exp_q.push_back('{ch: i, ph: ph[i*PH_W +: PH_W], last: (i == hi)});

    bus.i_ph        = ph;
    bus.i_ch_mask   = mask;
    bus.i_ph_en     = 1'b1;
    bus.i_rec_ready = 1'b0;
    @(negedge clk);
    bus.i_ph_en   = 1'b0;
    bus.i_ph      = rand_ph();
    bus.i_ch_mask = NCH'($urandom);
    chk("overrun_on_idle_strobe", bus.o_overrun, 0);

    if (exp_q.size() == 0) begin
      chk("zero_mask_valid", bus.o_rec_valid, 0);
      chk("zero_mask_busy", bus.o_busy, 0);
      chk("zero_mask_seq", bus.o_rec_seq, exp_seq[7:0]);
      return;
    end

    cyc = 0;
    stall = 0;
    strobed = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      chk("rec_valid", bus.o_rec_valid, 1);
      chk("busy", bus.o_busy, 1);
      chk("rec_ch", bus.o_rec_ch, exp_q[0].ch);
      chk("rec_ph", bus.o_rec_ph, exp_q[0].ph);
      chk("rec_last", bus.o_rec_last, exp_q[0].last);
      chk("seq_in_frame", bus.o_rec_seq, exp_seq[7:0]);
      chk("overrun_pulse", bus.o_overrun, strobed);

      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = ($urandom_range(0, 1) == 1) || (stall >= 4);
      endcase
      stall = rdy ? 0 : stall + 1;
      bus.i_rec_ready = rdy;

      strobed = ((strb_mode & 1) != 0 && cyc == 0) ||
                ((strb_mode & 2) != 0 && rdy && exp_q.size() == 1);
      bus.i_ph_en = strobed;
      if (strobed) exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;

      if (rdy) void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
      bus.i_ph_en     = 1'b0;
      bus.i_rec_ready = 1'b0;
    end

    chk("frame_complete", exp_q.size(), 0);
    exp_seq = (exp_seq + 1) % 256;
    chk("end_valid", bus.o_rec_valid, 0);
    chk("end_busy", bus.o_busy, 0);
    chk("end_seq", bus.o_rec_seq, exp_seq[7:0]);
    chk("end_overrun", bus.o_overrun, strobed);
    chk("end_timeout", bus.o_timeout, 0);
    chk("drop_cnt", bus.o_drop_cnt, exp_drops[7:0]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.o_rec_valid, 0);
    chk({tag, "_ch"}, bus.o_rec_ch, 0);
    chk({tag, "_ph"}, bus.o_rec_ph, 0);
    chk({tag, "_last"}, bus.o_rec_last, 0);
    chk({tag, "_seq"}, bus.o_rec_seq, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_overrun"}, bus.o_overrun, 0);
    chk({tag, "_timeout"}, bus.o_timeout, 0);
    chk({tag, "_drop_cnt"}, bus.o_drop_cnt, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_seq = 0;
    exp_drops = 0;
    rst = 1'b1;
    bus.i_ph_en = 1'b0;
    bus.i_ph = '0;
    bus.i_ch_mask = '0;
    bus.i_rec_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // All four channels, ready high: one record per cycle, last on ch3.
    run_frame(4'b1111, {29'd400, 29'd300, 29'd200, 29'd100}, 0, 0);
    // Sparse mask with ready every third cycle: outputs must hold while stalled.
    run_frame(4'b1010, rand_ph(), 1, 0);
    // Strobes mid-frame and on the last handshake, then a strobe right after.
    run_frame(4'b0111, rand_ph(), 0, 3);
    run_frame(4'b1001, rand_ph(), 2, 0);
    // Empty mask produces nothing.
    run_frame(4'b0000, rand_ph(), 0, 0);
    @(negedge clk);
    chk("zero_mask_idle_valid", bus.o_rec_valid, 0);
    chk("zero_mask_idle_busy", bus.o_busy, 0);

    // Watchdog: ready held low.
    bus.i_ch_mask = 4'b0110;
    bus.i_ph = rand_ph();
    bus.i_ph_en = 1'b1;
    bus.i_rec_ready = 1'b0;
    @(negedge clk);
    bus.i_ph_en = 1'b0;
    for (int j = 0; j < TO_CYC; j++) begin
      chk("wd_valid_held", bus.o_rec_valid, 1);
      chk("wd_ch_held", bus.o_rec_ch, 1);
      chk("wd_no_timeout", bus.o_timeout, 0);
      @(negedge clk);
    end
    exp_seq = (exp_seq + 1) % 256;
    chk("wd_timeout", bus.o_timeout, 1);
    chk("wd_valid_drop", bus.o_rec_valid, 0);
    chk("wd_busy_drop", bus.o_busy, 0);
    chk("wd_seq", bus.o_rec_seq, exp_seq[7:0]);
    @(negedge clk);
    chk("wd_timeout_width", bus.o_timeout, 0);
    run_frame(rand_mask_nz(), rand_ph(), 2, 0);

    // Reset in the middle of a stalled frame.
    bus.i_ch_mask = 4'b1111;
    bus.i_ph = rand_ph();
    bus.i_ph_en = 1'b1;
    @(negedge clk);
    bus.i_ph_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_drops", bus.o_drop_cnt, exp_drops[7:0]);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midframe_reset");
    rst = 1'b0;
    exp_seq = 0;
    exp_drops = 0;
    @(negedge clk);
    chk("post_reset_idle", bus.o_rec_valid, 0);

    // 256 frames wrap the sequence number; one drop per frame saturates the counter.
    for (int f = 0; f < 256; f++) run_frame(rand_mask_nz(), rand_ph(), 2, 1);
    chk("seq_wrapped", bus.o_rec_seq, 0);
    chk("drop_cnt_saturated", bus.o_drop_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
